// File: rtl/bird_physics_if.sv
// bird_physics_if: frame/flap/collision inputs and Y/velocity/state outputs
// of the bird physics block, bundled for the renderer and collision logic.
//   master : drives i_Frame_end, i_Flap, i_Collision; observes the outputs
//   slave  : the bird_physics block itself
interface bird_physics_if #(
  parameter int VIS_H = 480,
  parameter int VEL_W = 6
);
  localparam int Y_W = $clog2(VIS_H);

  logic                    i_Frame_end;
  logic                    i_Flap;
  logic                    i_Collision;
  logic [Y_W-1:0]          o_Bird_Y;
  logic signed [VEL_W-1:0] o_Velocity;
  logic [1:0]              o_State;
  logic                    o_Game_over;

  modport master (
    output i_Frame_end, i_Flap, i_Collision,
    input  o_Bird_Y, o_Velocity, o_State, o_Game_over
  );

  modport slave (
    input  i_Frame_end, i_Flap, i_Collision,
    output o_Bird_Y, o_Velocity, o_State, o_Game_over
  );
endinterface

// File: rtl/bird_physics.sv
// bird_physics: per-frame vertical motion and life-cycle controller for the
// player bird. Gravity/flap physics is applied once per i_Frame_end pulse;
// all outputs are registered.
// Ports:
//   i_Clk, i_Rst_n : clock, synchronous active-low reset
//   bus (slave)    : i_Frame_end, i_Flap, i_Collision in;
//                    o_Bird_Y, o_Velocity, o_State, o_Game_over out
// Optional build macro BIRD_HOVER_EN: bird bobs START_Y-2..START_Y while IDLE.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting at spawn, flap edge launches
// ST_FLY   | gravity + flap impulses, ceiling clamp, floor kills
// ST_DYING | hit a pipe, gravity only until the floor
// ST_DEAD  | frozen, game over, flap edge respawns
module bird_physics #(
  parameter int VIS_H        = 480,
  parameter int BIRD_H       = 16,
  parameter int START_Y      = 232,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 8,
  parameter int MAX_FALL     = 10,
  parameter int VEL_W        = 6
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  bird_physics_if.slave bus
);
  localparam int Y_W = $clog2(VIS_H);
  localparam int S_W = Y_W + 2;
  localparam logic signed [S_W-1:0] FLOOR_S = S_W'(VIS_H - BIRD_H);
  localparam logic signed [S_W-1:0] GRAV_S  = S_W'(GRAVITY);
  localparam logic signed [S_W-1:0] MAXF_S  = S_W'(MAX_FALL);
  localparam logic signed [S_W-1:0] FLAP_S  = S_W'(FLAP_IMPULSE);
  localparam logic [Y_W-1:0]        START_U = Y_W'(START_Y);
  localparam logic [Y_W-1:0]        FLOOR_U = Y_W'(VIS_H - BIRD_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FLY   = 2'b01,
    ST_DYING = 2'b10,
    ST_DEAD  = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    flap_prev_q;
  logic                    flap_pending_q, flap_pending_d;
  logic                    game_over_q;

  logic                    flap_edge;
  logic                    dying;
  logic signed [S_W-1:0]   vel_ext, y_ext, vel_grav_raw, vel_grav, vel_next, y_next;
  logic [Y_W-1:0]          idle_y;

  assign flap_edge    = bus.i_Flap & ~flap_prev_q;
  // A collision seen in the same cycle as a frame update already forces
  // the DYING rules for that update.
  assign dying        = (state_q == ST_DYING) || ((state_q == ST_FLY) && bus.i_Collision);
  assign vel_ext      = S_W'(vel_q);
  assign y_ext        = signed'({2'b00, y_q});
  assign vel_grav_raw = vel_ext + GRAV_S;
  assign vel_grav     = (vel_grav_raw > MAXF_S) ? MAXF_S : vel_grav_raw;
  assign vel_next     = (!dying && (flap_pending_q || flap_edge)) ? -FLAP_S : vel_grav;
  assign y_next       = y_ext + vel_next;

`ifdef BIRD_HOVER_EN
  logic [2:0] hover_cnt_q, hover_cnt_d;
  logic [1:0] hover_ph_q, hover_ph_d;
  logic [1:0] hover_off;

  // Phase 0..3 maps to offsets 0,-1,-2,-1; counters clear outside IDLE.
  always_comb begin
    hover_cnt_d = '0;
    hover_ph_d  = '0;
    if (state_q == ST_IDLE && !flap_edge) begin
      hover_cnt_d = hover_cnt_q;
      hover_ph_d  = hover_ph_q;
      if (bus.i_Frame_end) begin
        hover_cnt_d = hover_cnt_q + 3'd1;
        if (hover_cnt_q == 3'd7) hover_ph_d = hover_ph_q + 2'd1;
      end
    end
  end

  assign hover_off = (hover_ph_d == 2'd3) ? 2'd1 : hover_ph_d;
  assign idle_y    = START_U - {{(Y_W-2){1'b0}}, hover_off};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      hover_cnt_q <= '0;
      hover_ph_q  <= '0;
    end else begin
      hover_cnt_q <= hover_cnt_d;
      hover_ph_q  <= hover_ph_d;
    end
  end
`else
  assign idle_y = START_U;
`endif

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    vel_d          = vel_q;
    flap_pending_d = flap_pending_q;
    unique case (state_q)
      ST_IDLE: begin
        vel_d = '0;
        if (flap_edge) begin
          // Pending flap survives so the first FLY update launches.
          state_d        = ST_FLY;
          flap_pending_d = 1'b1;
        end else begin
          y_d = idle_y;
        end
      end
      ST_FLY, ST_DYING: begin
        if (dying) begin
          state_d        = ST_DYING;
          flap_pending_d = 1'b0;
        end else if (bus.i_Frame_end) begin
          flap_pending_d = 1'b0;
        end else begin
          flap_pending_d = flap_pending_q | flap_edge;
        end
        if (bus.i_Frame_end) begin
          if (y_next < 0) begin
            y_d   = '0;
            vel_d = '0;
          end else if (y_next >= FLOOR_S) begin
            y_d     = FLOOR_U;
            vel_d   = '0;
            state_d = ST_DEAD;
          end else begin
            y_d   = y_next[Y_W-1:0];
            vel_d = vel_next[VEL_W-1:0];
          end
        end
      end
      ST_DEAD: begin
        if (flap_edge) begin
          state_d        = ST_IDLE;
          y_d            = START_U;
          vel_d          = '0;
          flap_pending_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q        <= ST_IDLE;
      y_q            <= START_U;
      vel_q          <= '0;
      flap_prev_q    <= 1'b0;
      flap_pending_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      vel_q          <= vel_d;
      flap_prev_q    <= bus.i_Flap;
      flap_pending_q <= flap_pending_d;
      game_over_q    <= (state_d == ST_DEAD);
    end
  end

  assign bus.o_Bird_Y    = y_q;
  assign bus.o_Velocity  = vel_q;
  assign bus.o_State     = state_q;
  assign bus.o_Game_over = game_over_q;
endmodule

// File: tb/tb_bird_physics.sv
module tb_bird_physics;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bird_physics_if #(.VIS_H(480), .VEL_W(6)) bus ();

  bird_physics dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 IDLE, 1 FLY, 2 DYING, 3 DEAD
  int m_state, m_y, m_vel;
  bit m_pend, m_prev;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit fe, bit flap, bit col);
    bit edge_seen, dy;
    int v, ny;
    if (!r) begin
      m_state = 0; m_y = 232; m_vel = 0; m_pend = 0; m_prev = 0;
      return;
    end
    edge_seen = flap && !m_prev;
    m_prev = flap;
    case (m_state)
      0: if (edge_seen) begin m_state = 1; m_pend = 1; end
      1, 2: begin
        dy = (m_state == 2) || col;
        if (dy) begin m_state = 2; m_pend = 0; end
        else if (edge_seen) m_pend = 1;
        if (fe) begin
          if (!dy && m_pend) v = -8;
          else v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
          m_pend = 0;
          ny = m_y + v;
          if (ny < 0) begin m_y = 0; m_vel = 0; end
          else if (ny >= 464) begin m_y = 464; m_vel = 0; m_state = 3; end
          else begin m_y = ny; m_vel = v; end
        end
      end
      default: if (edge_seen) begin m_state = 0; m_y = 232; m_vel = 0; m_pend = 0; end
    endcase
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic apply(bit r, bit fe, bit flap, bit col);
    rst_n           = r;
    bus.i_Frame_end = fe;
    bus.i_Flap      = flap;
    bus.i_Collision = col;
    @(posedge clk);
    #1;
    model_step(r, fe, flap, col);
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".state"}, int'(bus.o_State), m_state);
    chk({tag, ".y"}, int'(bus.o_Bird_Y), m_y);
    chk({tag, ".vel"}, int'(bus.o_Velocity), m_vel);
    chk({tag, ".go"}, int'(bus.o_Game_over), (m_state == 3) ? 1 : 0);
  endtask

  task automatic chk_const(string tag, int st, int y, int vel, int go);
    chk({tag, ".state"}, int'(bus.o_State), st);
    chk({tag, ".y"}, int'(bus.o_Bird_Y), y);
    chk({tag, ".vel"}, int'(bus.o_Velocity), vel);
    chk({tag, ".go"}, int'(bus.o_Game_over), go);
  endtask

  typedef struct {
    bit r; bit fe; bit flap; bit col;
    int st; int y; int vel; int go;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit done;
    int maxv;
    bit flap_lvl;

    tbl[0]  = '{0, 0, 0, 0, 0, 232,  0, 0};  // reset
    tbl[1]  = '{1, 0, 1, 0, 1, 232,  0, 0};  // flap edge in IDLE -> FLY
    tbl[2]  = '{1, 1, 0, 0, 1, 224, -8, 0};  // first update applies impulse
    tbl[3]  = '{1, 0, 0, 0, 1, 224, -8, 0};  // stable mid-frame
    tbl[4]  = '{1, 1, 0, 0, 1, 217, -7, 0};
    tbl[5]  = '{1, 1, 0, 0, 1, 211, -6, 0};
    tbl[6]  = '{1, 1, 1, 0, 1, 203, -8, 0};  // edge coincident with frame end
    tbl[7]  = '{1, 1, 1, 0, 1, 196, -7, 0};  // held level, no new edge
    tbl[8]  = '{1, 0, 0, 1, 2, 196, -7, 0};  // collision -> DYING
    tbl[9]  = '{1, 1, 1, 0, 2, 190, -6, 0};  // flap ignored while dying
    tbl[10] = '{0, 0, 0, 0, 0, 232,  0, 0};  // reset mid-DYING

    bus.i_Frame_end = 1'b0;
    bus.i_Flap      = 1'b0;
    bus.i_Collision = 1'b0;

    // Idle after reset for 10 frames
    apply(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk_const("rst", 0, 232, 0, 0);
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 4; c++) apply(1, 0, 0, 0);
      apply(1, 1, 0, 0);
      chk_const("idle", 0, 232, 0, 0);
    end

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].fe, tbl[i].flap, tbl[i].col);
      chk_const($sformatf("vec%0d", i), tbl[i].st, tbl[i].y, tbl[i].vel, tbl[i].go);
    end

    // Launch then free fall to the floor
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 0);
    apply(1, 0, 0, 0);
    done = 0;
    maxv = -100;
    for (int f = 0; f < 100 && !done; f++) begin
      apply(1, 1, 0, 0);
      chk_model("fall");
      if (int'(bus.o_Velocity) > maxv) maxv = int'(bus.o_Velocity);
      done = (bus.o_State == 2'b11);
      apply(1, 0, 0, 0);
    end
    chk("fall.reached_floor", int'(done), 1);
    chk("fall.maxvel", maxv, 10);
    chk_const("fall.end", 3, 464, 0, 1);
    apply(1, 1, 0, 0);
    chk_const("dead.frozen", 3, 464, 0, 1);
    apply(1, 0, 1, 0);
    chk_const("respawn", 0, 232, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 1, 0, 0);
    chk_const("respawn.nolaunch", 0, 232, 0, 0);

    // Flap every frame up into the ceiling
    apply(0, 0, 0, 0);
    for (int f = 0; f < 40; f++) begin
      apply(1, 1, 1, 0);
      chk_model("ceil");
      apply(1, 0, 0, 0);
    end
    chk_const("ceil.end", 1, 0, 0, 0);

    // Collision coincident with frame end and flap, then gravity to floor
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 0);
    apply(1, 0, 0, 0);
    apply(1, 1, 1, 1);
    chk_const("hit", 2, 233, 1, 0);
    done = 0;
    for (int f = 0; f < 100 && !done; f++) begin
      apply(1, 0, 0, 0);
      apply(1, 1, 0, 0);
      chk_model("dying");
      done = (bus.o_State == 2'b11);
    end
    chk("dying.reached_floor", int'(done), 1);
    chk_const("dying.end", 3, 464, 0, 1);
    apply(1, 0, 0, 0);
    apply(1, 0, 1, 0);
    chk_const("dying.respawn", 0, 232, 0, 0);

    // Randomised run against the model
    apply(0, 0, 0, 0);
    flap_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, fe, col;
      if ($urandom_range(3) == 0) flap_lvl = ~flap_lvl;
      fe  = ($urandom_range(9) == 0);
      col = ($urandom_range(59) == 0);
      r   = ($urandom_range(299) != 0);
      apply(r, fe, flap_lvl, col);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
